// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - states, opcodes, select encodings and per-state control decode
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_OFFSET = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Moore part of the outputs plus state flags that gate the input-dependent ones.
  typedef struct packed {
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       in_fetch;
    logic       in_decode;
    logic       in_exec;
    logic       in_branch;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = SRC_B_FOUR;
        c.in_fetch  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = SRC_B_OFFSET;
        c.in_decode = 1'b1;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_OP_FUNCT;
        c.in_exec   = 1'b1;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_OP_SUB;
        c.pc_src    = PC_SRC_ALUOUT;
        c.in_branch = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = PC_SRC_JUMP;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_dispatch.sv
// rtl/multicycle_control_dispatch.sv - combinational opcode to post-DECODE state mapping
module opcode_dispatch
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output state_e              dispatch_state,
  output logic                illegal,
  output logic                is_load
);

  localparam logic [OPCODE_W-1:0] LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] SW    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] ADDI  = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] J     = OPCODE_W'(OP_J);

  always_comb begin
    dispatch_state = S_FETCH;
    illegal        = 1'b0;
    is_load        = (opcode == LW);
    if (opcode == LW || opcode == SW) begin
      dispatch_state = S_MEMADR;
    end else if (opcode == RTYPE) begin
      dispatch_state = S_EXEC;
    end else if (opcode == BEQ) begin
      dispatch_state = S_BRANCH;
    end else if (opcode == ADDI) begin
      dispatch_state = S_ADDIEX;
    end else if (opcode == J) begin
      dispatch_state = S_JUMP;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath control FSM
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_write,
  output logic                illegal_op,
  output logic                iord,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [STATE_W-1:0]  state_dbg
);

  state_e state;
  state_e next_state;
  state_e dispatch_state;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl;
  logic   dispatch_illegal;
  logic   is_load;

  opcode_dispatch #(
    .OPCODE_W(OPCODE_W)
  ) u_dispatch (
    .opcode         (opcode),
    .dispatch_state (dispatch_state),
    .illegal        (dispatch_illegal),
    .is_load        (is_load)
  );

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: next_state = dispatch_state;
      S_MEMADR: next_state = is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state so it always matches state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH);
    end else begin
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state);
    end
  end

  // While held in reset the outputs show FETCH selects with every strobe low.
  always_comb begin
    ctrl       = rst_n ? ctrl_q : state_ctrl(S_FETCH);
    iord       = ctrl.iord;
    reg_dst    = ctrl.reg_dst;
    mem_to_reg = ctrl.mem_to_reg;
    alu_src_a  = ctrl.alu_src_a;
    alu_op     = ctrl.alu_op;
    pc_src     = ctrl.pc_src;
    alu_src_b  = (ctrl.in_exec && funct == '0) ? SRC_B_IMM : ctrl.alu_src_b;
    ir_write   = rst_n & ctrl.in_fetch & mem_ready;
    pc_write   = rst_n & (ctrl.pc_write | (ctrl.in_fetch & mem_ready) | (ctrl.in_branch & zero));
    mem_write  = rst_n & ctrl.mem_write;
    reg_write  = rst_n & ctrl.reg_write;
    illegal_op = rst_n & ctrl.in_decode & dispatch_illegal;
    state_dbg  = rst_n ? STATE_W'(state) : STATE_W'(S_FETCH);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized instruction stream against a per-instruction cycle script
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       zero;
  logic       pc_write, ir_write, mem_write, reg_write, illegal_op;
  logic       iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_dbg;
  logic [14:0] outvec;

  int checks = 0;
  int errors = 0;

  // {pc_write, ir_write, mem_write, reg_write, illegal_op, iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}
  localparam logic [14:0] E_FETCH_WAIT = 15'b00000_0000_01_00_00;
  localparam logic [14:0] E_FETCH_GO   = 15'b11000_0000_01_00_00;
  localparam logic [14:0] E_MEMADR     = 15'b00000_0001_10_00_00;
  localparam logic [14:0] E_MEMRD      = 15'b00000_1000_00_00_00;
  localparam logic [14:0] E_MEMWB      = 15'b00010_0010_00_00_00;
  localparam logic [14:0] E_MEMWR      = 15'b00100_1000_00_00_00;
  localparam logic [14:0] E_ALUWB      = 15'b00010_0100_00_00_00;
  localparam logic [14:0] E_ADDIEX     = 15'b00000_0001_10_00_00;
  localparam logic [14:0] E_ADDIWB     = 15'b00010_0000_00_00_00;
  localparam logic [14:0] E_JUMP       = 15'b10000_0000_00_00_10;

  multicycle_control #(
    .OPCODE_W(6),
    .FUNCT_W (6),
    .STATE_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .illegal_op (illegal_op),
    .iord       (iord),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state_dbg  (state_dbg)
  );

  assign outvec = {pc_write, ir_write, mem_write, reg_write, illegal_op,
                   iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Called just after a rising edge; applies inputs, checks mid-cycle, advances one cycle.
  task automatic step(input string tag, input state_e s, input logic ready, input logic zb,
                      input logic [14:0] exp);
    mem_ready = ready;
    zero      = zb;
    @(negedge clk);
    check_eq({tag, "_state"}, 32'(state_dbg), 32'(s));
    check_eq({tag, "_out"}, 32'(outvec), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zb,
                           input int fs, input int ms);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < fs; i++) step("fetch_wait", S_FETCH, 1'b0, rbit(), E_FETCH_WAIT);
    step("fetch", S_FETCH, 1'b1, rbit(), E_FETCH_GO);
    step("decode", S_DECODE, rbit(), rbit(), {4'b0000, ~legal(op), 4'b0000, 2'b11, 2'b00, 2'b00});
    case (op)
      6'b100011: begin
        step("lw_memadr", S_MEMADR, rbit(), rbit(), E_MEMADR);
        for (int i = 0; i < ms; i++) step("memrd_wait", S_MEMRD, 1'b0, rbit(), E_MEMRD);
        step("memrd", S_MEMRD, 1'b1, rbit(), E_MEMRD);
        step("memwb", S_MEMWB, rbit(), rbit(), E_MEMWB);
      end
      6'b101011: begin
        step("sw_memadr", S_MEMADR, rbit(), rbit(), E_MEMADR);
        for (int i = 0; i < ms; i++) step("memwr_wait", S_MEMWR, 1'b0, rbit(), E_MEMWR);
        step("memwr", S_MEMWR, 1'b1, rbit(), E_MEMWR);
      end
      6'b000000: begin
        step("exec", S_EXEC, rbit(), rbit(),
             {4'b0000, 1'b0, 4'b0001, (fn == 6'd0) ? 2'b10 : 2'b00, 2'b10, 2'b00});
        step("aluwb", S_ALUWB, rbit(), rbit(), E_ALUWB);
      end
      6'b000100: begin
        step("branch", S_BRANCH, rbit(), zb, {zb, 4'b0000, 4'b0001, 2'b00, 2'b01, 2'b01});
      end
      6'b001000: begin
        step("addiex", S_ADDIEX, rbit(), rbit(), E_ADDIEX);
        step("addiwb", S_ADDIWB, rbit(), rbit(), E_ADDIWB);
      end
      6'b000010: step("jump", S_JUMP, rbit(), rbit(), E_JUMP);
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    logic [5:0] fn;
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b000010; funct = 6'd0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", 32'(state_dbg), 32'(S_FETCH));
    check_eq("rst_out", 32'(outvec), 32'(E_FETCH_WAIT));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr(6'b100011, 6'd5, 1'b0, 0, 0);
    run_instr(6'b101011, 6'd5, 1'b0, 0, 3);
    run_instr(6'b000100, 6'd1, 1'b1, 0, 0);
    run_instr(6'b000100, 6'd1, 1'b0, 1, 0);
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    run_instr(6'b001000, 6'd0, 1'b0, 2, 0);
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0);
    run_instr(6'b100011, 6'd0, 1'b0, 1, 2);

    // Reset arriving while a store is stalled in MEMWR.
    opcode = 6'b101011;
    step("mr_fetch", S_FETCH, 1'b1, 1'b0, E_FETCH_GO);
    step("mr_decode", S_DECODE, 1'b0, 1'b0, {4'b0000, 1'b0, 4'b0000, 2'b11, 2'b00, 2'b00});
    step("mr_memadr", S_MEMADR, 1'b0, 1'b0, E_MEMADR);
    step("mr_memwr", S_MEMWR, 1'b0, 1'b0, E_MEMWR);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("mr_in_rst_out", 32'(outvec), 32'(E_FETCH_WAIT));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("mr_after", S_FETCH, 1'b0, 1'b0, E_FETCH_WAIT);

    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      run_instr(op, fn, rbit(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 6, meaning the instruction opcode field width.
REQ-002 The block SHALL have parameter FUNCT_W, default 6, meaning the R-type funct field width.
REQ-003 The block SHALL have parameter STATE_W, default 4, meaning the width of the state_dbg encoding.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes occur on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset; reset is synchronous and active-low.
REQ-006 The block SHALL have port opcode, input, OPCODE_W, meaning the opcode of the held instruction register.
REQ-007 The block SHALL have port funct, input, FUNCT_W, meaning the funct field of the held instruction register.
REQ-008 The block SHALL have port mem_ready, input, 1, meaning the memory access completes this cycle.
REQ-009 The block SHALL have port zero, input, 1, meaning the ALU equality flag.
REQ-010 The block SHALL have output strobes pc_write, ir_write, mem_write, reg_write and illegal_op, 1 bit each.
REQ-011 The block SHALL have output selects iord, reg_dst, mem_to_reg and alu_src_a, 1 bit each.
REQ-012 The block SHALL have output selects alu_src_b, alu_op and pc_src, 2 bits each.
REQ-013 The block SHALL have output state_dbg, STATE_W bits, meaning the current state encoding.

Function
REQ-014 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP.
- Exception: branch-taken and shift selection are the only input-dependent outputs.
REQ-015 FETCH SHALL drive iord=0, alu_src_a=0, alu_src_b=01 (+4), alu_op=00 and pc_src=00.
- It SHALL stay in FETCH while mem_ready=0, with ir_write=pc_write=0.
- When mem_ready=1, it SHALL drive ir_write=pc_write=1 for that single cycle and go to DECODE.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11 (branch offset) and alu_op=00.
- Opcode dispatch: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
- Any other opcode: illegal_op=1 for one cycle, then -> FETCH.
REQ-017 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00.
- Next state: MEMRD for opcode 100011, MEMWR for opcode 101011.
REQ-018 MEMRD SHALL drive iord=1 and wait on mem_ready, then -> MEMWB.
- MEMWB SHALL drive reg_dst=0, mem_to_reg=1 and reg_write=1, then -> FETCH.
REQ-019 MEMWR SHALL drive iord=1 and assert mem_write continuously until the cycle in which mem_ready=1, then -> FETCH.
REQ-020 EXEC SHALL drive alu_src_a=1 and alu_op=10, then -> ALUWB.
- alu_src_b SHALL be 00 normally, and 10 when funct equals 0 (shift-amount path).
- ALUWB SHALL drive reg_dst=1, mem_to_reg=0 and reg_write=1, then -> FETCH.
REQ-021 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01 and pc_src=01, then -> FETCH.
- It SHALL drive pc_write=zero in the same cycle.
REQ-022 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then -> ADDIWB.
- ADDIWB SHALL drive reg_dst=0, mem_to_reg=0 and reg_write=1, then -> FETCH.
REQ-023 JUMP SHALL drive pc_src=10 and pc_write=1, then -> FETCH.
REQ-024 Every output not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-025 Instruction latencies with mem_ready held high SHALL be:
- lw 5 cycles; sw, R-type and addi 4 cycles each; beq and j 3 cycles each.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-026 Any unreachable state encoding SHALL return to FETCH on the next edge.

Reset
REQ-027 When rst_n=0 at a rising edge, the state SHALL become FETCH, regardless of the current state.
- This includes a reset arriving mid-MEMWR or mid-stall.
REQ-028 While rst_n=0, the block SHALL force pc_write, ir_write, mem_write, reg_write and illegal_op to 0.
- All select outputs SHALL take their FETCH values and state_dbg SHALL read the FETCH encoding.

Structure
REQ-029 The shared package SHALL hold the state enumeration, the opcode constants, and the alu_op, alu_src_b and pc_src encodings.
REQ-030 Dispatch decode SHALL be one sub-module, opcode_dispatch: purely combinational, mapping opcode to next-state and illegal flag.

Verification
REQ-031 Reset then lw (100011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-032 sw with mem_ready low for 3 cycles in MEMWR -> mem_write high 4 cycles, then FETCH; reg_write never 1.
REQ-033 beq with zero=1, then with zero=0 -> pc_write=1 with pc_src=01 in BRANCH for the first case, pc_write=0 for the second.
REQ-034 R-type funct=000000 vs funct=100000 -> alu_src_b=10 vs 00 in EXEC; ALUWB has reg_dst=1.
REQ-035 Opcode 111111 -> illegal_op pulses exactly 1 cycle in DECODE, next state FETCH, no write strobes asserted.
REQ-036 rst_n=0 asserted in MEMWR with mem_write=1 -> the next edge gives FETCH with mem_write=0.
